// File: rtl/alu_result_serializer_pkg.sv
// Shared definitions for the ALU result serializer and the arithmetic unit feeding it.
// Holds the serializer FSM encoding and the default datapath widths.
// No logic; imported by every file of the serializer.
package alu_result_serializer_pkg;

    localparam int DEF_OUT_DATA_WIDTH = 32;
    localparam int DEF_BYTE_WIDTH     = 8;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_e;

    // Number of result bytes in a frame (the status byte comes on top)
    function automatic int result_bytes(input int out_w, input int byte_w);
        return out_w / byte_w;
    endfunction

endpackage

// File: rtl/result_hold_buffer.sv
// One-entry holding register for a result that arrives while a frame is in flight.
// Latency: written data visible on rd_data the cycle after wr.
// A simultaneous write and drain replaces the entry and keeps it full.
module result_hold_buffer
    import alu_result_serializer_pkg::*;
#(
    parameter int W = DEF_OUT_DATA_WIDTH + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr,
    input  logic [W-1:0] wr_data,
    input  logic         drain,
    output logic         full,
    output logic [W-1:0] rd_data
);

    // Entry and occupancy flag; write wins over drain so drain+write stays full
    always_ff @(posedge clk) begin
        if (rst) begin
            full    <= 1'b0;
            rd_data <= '0;
        end else if (wr) begin
            full    <= 1'b1;
            rd_data <= wr_data;
        end else if (drain) begin
            full    <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_result_serializer.sv
// Serializes each captured {carry, result} into result bytes (LSB first) plus a status byte.
// Latency: byte 0 offered one cycle after the strobe; frames run back to back with no gap.
// Bytes hold while TX_BUSY is high; one result is buffered, a further one is dropped with OVF.
module alu_result_serializer
    import alu_result_serializer_pkg::*;
#(
    parameter int OUT_DATA_WIDTH = DEF_OUT_DATA_WIDTH,
    parameter int BYTE_WIDTH     = DEF_BYTE_WIDTH
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [OUT_DATA_WIDTH-1:0] Arith_OUT,
    input  logic                      Carry_OUT,
    input  logic                      Arith_Flag,
    input  logic                      TX_BUSY,
    output logic [BYTE_WIDTH-1:0]     TX_P_DATA,
    output logic                      TX_D_VLD,
    output logic                      SER_BUSY,
    output logic                      OVF
);

    localparam int N  = result_bytes(OUT_DATA_WIDTH, BYTE_WIDTH);
    localparam int IW = $clog2(N + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(N);
    localparam int RW = OUT_DATA_WIDTH + 1;

    ser_state_e                state;
    logic [IW-1:0]             idx;
    logic [OUT_DATA_WIDTH-1:0] shreg;
    logic                      carry_q;

    logic          buf_full;
    logic [RW-1:0] buf_data;

    logic          accept;
    logic          last_acc;
    logic          load_from_buf;
    logic          load_from_in;
    logic          load_en;
    logic [RW-1:0] load_word;
    logic          buf_wr;
    logic          buf_drain;
    logic          ovf_c;
    logic          full_nxt;
    ser_state_e    state_nxt;

    // Handshake decode, frame-end decisions and next-cycle occupancy
    always_comb begin
        accept        = TX_D_VLD && !TX_BUSY;
        last_acc      = (state == SEND) && accept && (idx == LAST_IDX);
        load_from_buf = last_acc && buf_full;
        load_from_in  = Arith_Flag && ((state == IDLE) || (last_acc && !buf_full));
        load_en       = load_from_buf || load_from_in;
        load_word     = load_from_buf ? buf_data : {Carry_OUT, Arith_OUT};
        // Buffer is written when empty mid-frame, or refilled as it drains at frame end
        buf_wr        = (state == SEND) && Arith_Flag && (buf_full == last_acc);
        buf_drain     = load_from_buf;
        ovf_c         = (state == SEND) && Arith_Flag && buf_full && !last_acc;
        full_nxt      = buf_wr || (buf_full && !buf_drain);
        state_nxt     = state;
        if (load_en) begin
            state_nxt = SEND;
        end else if (last_acc) begin
            state_nxt = IDLE;
        end
    end

    result_hold_buffer #(
        .W (RW)
    ) u_hold (
        .clk     (CLK),
        .rst     (RST),
        .wr      (buf_wr),
        .wr_data ({Carry_OUT, Arith_OUT}),
        .drain   (buf_drain),
        .full    (buf_full),
        .rd_data (buf_data)
    );

    // Frame FSM with registered byte, valid, busy and overflow outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            idx       <= '0;
            shreg     <= '0;
            carry_q   <= 1'b0;
            TX_P_DATA <= '0;
            TX_D_VLD  <= 1'b0;
            SER_BUSY  <= 1'b0;
            OVF       <= 1'b0;
        end else begin
            state    <= state_nxt;
            OVF      <= ovf_c;
            SER_BUSY <= (state_nxt == SEND) || full_nxt;
            if (load_en) begin
                idx       <= '0;
                shreg     <= load_word[OUT_DATA_WIDTH-1:0] >> BYTE_WIDTH;
                carry_q   <= load_word[OUT_DATA_WIDTH];
                TX_P_DATA <= load_word[BYTE_WIDTH-1:0];
                TX_D_VLD  <= 1'b1;
            end else if (last_acc) begin
                idx       <= '0;
                TX_P_DATA <= '0;
                TX_D_VLD  <= 1'b0;
            end else if ((state == SEND) && accept) begin
                idx <= idx + 1'b1;
                if (idx == LAST_IDX - 1'b1) begin
                    TX_P_DATA <= {{(BYTE_WIDTH-1){1'b0}}, carry_q};
                end else begin
                    TX_P_DATA <= shreg[BYTE_WIDTH-1:0];
                    shreg     <= shreg >> BYTE_WIDTH;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_result_serializer.sv
// Bench for alu_result_serializer: directed scenarios plus random traffic against a frame-queue model.
module tb_alu_result_serializer;

    localparam int OW = 32;
    localparam int BW = 8;
    localparam int N  = OW / BW;

    logic          CLK = 1'b0;
    logic          RST;
    logic [OW-1:0] Arith_OUT;
    logic          Carry_OUT;
    logic          Arith_Flag;
    logic          TX_BUSY;
    logic [BW-1:0] TX_P_DATA;
    logic          TX_D_VLD;
    logic          SER_BUSY;
    logic          OVF;

    always #5 CLK = ~CLK;

    alu_result_serializer #(
        .OUT_DATA_WIDTH (OW),
        .BYTE_WIDTH     (BW)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .Arith_OUT  (Arith_OUT),
        .Carry_OUT  (Carry_OUT),
        .Arith_Flag (Arith_Flag),
        .TX_BUSY    (TX_BUSY),
        .TX_P_DATA  (TX_P_DATA),
        .TX_D_VLD   (TX_D_VLD),
        .SER_BUSY   (SER_BUSY),
        .OVF        (OVF)
    );

    int errors = 0;
    int checks = 0;

    // Model: q[0] is the frame on the wire, q[1] the result waiting behind it
    logic [OW:0]   q[$];
    int            pos;
    bit            exp_ovf;
    logic [BW-1:0] got[$];
    int            ovf_cnt;
    logic          obs_vld;
    logic [BW-1:0] obs_byte;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [BW-1:0] frame_byte(input logic [OW:0] r, input int p);
        logic [OW-1:0] d;
        d = r[OW-1:0];
        if (p < N) return BW'(d >> (BW * p));
        return BW'(r[OW]);
    endfunction

    task automatic step(input bit rst, input bit flag, input logic [OW-1:0] d,
                        input bit c, input bit busy);
        @(negedge CLK);
        RST        = rst;
        Arith_Flag = flag;
        Arith_OUT  = d;
        Carry_OUT  = c;
        TX_BUSY    = busy;
        @(posedge CLK);
        exp_ovf = 1'b0;
        if (rst) begin
            q.delete();
            pos = 0;
        end else begin
            if (obs_vld && !busy) got.push_back(obs_byte);
            if (q.size() > 0 && !busy) begin
                if (pos == N) begin
                    void'(q.pop_front());
                    pos = 0;
                end else begin
                    pos++;
                end
            end
            if (flag) begin
                if (q.size() < 2) q.push_back({c, d});
                else exp_ovf = 1'b1;
            end
        end
        #1;
        chk("vld", TX_D_VLD, q.size() > 0);
        if (q.size() > 0) chk("byte", TX_P_DATA, frame_byte(q[0], pos));
        chk("ovf", OVF, exp_ovf);
        chk("ser_busy", SER_BUSY, q.size() > 0);
        if (rst) chk("rst_data", TX_P_DATA, 0);
        obs_vld  = TX_D_VLD;
        obs_byte = TX_P_DATA;
        if (OVF) ovf_cnt++;
    endtask

    task automatic idle(input int n, input bit busy);
        for (int i = 0; i < n; i++) step(0, 0, '0, 0, busy);
    endtask

    // Compare the accepted-byte log against bytes packed LSB-first in e
    task automatic check_log(input string tag, input int n, input logic [127:0] e);
        chk({tag, "_count"}, got.size(), n);
        for (int i = 0; i < n && i < got.size(); i++)
            chk(tag, got[i], e[8*i +: 8]);
    endtask

    task automatic clear_logs();
        got.delete();
        ovf_cnt = 0;
    endtask

    initial begin
        RST = 1'b1; Arith_Flag = 1'b0; Arith_OUT = '0; Carry_OUT = 1'b0; TX_BUSY = 1'b0;
        q.delete(); pos = 0; obs_vld = 1'b0; obs_byte = '0; ovf_cnt = 0;

        // Reset, including a strobe that must be ignored
        step(1, 0, '0, 0, 0);
        step(1, 1, 32'hCAFEF00D, 1, 0);
        chk("reset_vld", TX_D_VLD, 0);
        chk("reset_busy", SER_BUSY, 0);
        idle(2, 0);

        // Single result, no backpressure
        clear_logs();
        step(0, 1, 32'h12345678, 1, 0);
        chk("single_first", TX_P_DATA, 8'h78);
        idle(6, 0);
        check_log("single", 5, 128'h01_12_34_56_78);

        // Backpressure held on byte 2
        clear_logs();
        step(0, 1, 32'h12345678, 0, 0);
        idle(2, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, '0, 0, 1);
            chk("stall_hold", TX_P_DATA, 8'h34);
        end
        idle(5, 0);
        check_log("stall", 5, 128'h00_12_34_56_78);
        chk("stall_ovf", ovf_cnt, 0);

        // Second result buffered during the first frame
        clear_logs();
        step(0, 1, 32'h12345678, 1, 0);
        step(0, 1, 32'hAABBCCDD, 0, 0);
        idle(12, 0);
        check_log("buffered", 10, 128'h00_AA_BB_CC_DD_01_12_34_56_78);

        // Three strobes under full backpressure: third dropped
        clear_logs();
        step(0, 1, 32'h12345678, 1, 1);
        step(0, 1, 32'hAABBCCDD, 0, 1);
        step(0, 1, 32'hDEADBEEF, 1, 1);
        chk("ovf_pulse", OVF, 1);
        step(0, 0, '0, 0, 1);
        chk("ovf_single", OVF, 0);
        idle(14, 0);
        check_log("overflow", 10, 128'h00_AA_BB_CC_DD_01_12_34_56_78);
        chk("overflow_cnt", ovf_cnt, 1);

        // Strobe on the status-byte accept with the buffer full
        clear_logs();
        step(0, 1, 32'h12345678, 1, 0);
        step(0, 1, 32'hAABBCCDD, 0, 0);
        idle(3, 0);
        step(0, 1, 32'h0F0E0D0C, 1, 0);
        chk("simul_ovf", OVF, 0);
        idle(15, 0);
        check_log("simul", 15, 128'h01_0F_0E_0D_0C_00_AA_BB_CC_DD_01_12_34_56_78);
        chk("simul_cnt", ovf_cnt, 0);

        // Reset mid-frame after byte 1, then a fresh small result
        clear_logs();
        step(0, 1, 32'h12345678, 1, 0);
        idle(2, 0);
        step(1, 0, '0, 0, 0);
        chk("midrst_vld", TX_D_VLD, 0);
        chk("midrst_data", TX_P_DATA, 0);
        chk("midrst_busy", SER_BUSY, 0);
        idle(2, 0);
        clear_logs();
        step(0, 1, 32'h00000001, 0, 0);
        idle(6, 0);
        check_log("after_rst", 5, 128'h00_00_00_00_01);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 3) == 0),
                 $urandom, $urandom_range(0, 1),
                 ($urandom_range(0, 2) == 0));
        end
        idle(30, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_result_serializer.md
ALU_RESULT_SERIALIZER -- requirements
Module: alu_result_serializer

Interface
REQ-001 Parameter OUT_DATA_WIDTH, default 32: width of the captured arithmetic result.
REQ-002 Parameter BYTE_WIDTH, default 8: width of each transmitted frame byte; OUT_DATA_WIDTH SHALL be a multiple of BYTE_WIDTH.
REQ-003 CLK  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 Arith_OUT  input  OUT_DATA_WIDTH  arithmetic result, sampled when Arith_Flag is high.
REQ-006 Carry_OUT  input  1  carry bit accompanying Arith_OUT.
REQ-007 Arith_Flag  input  1  result-valid strobe; each high cycle is one distinct result.
REQ-008 TX_BUSY  input  1  downstream transmitter not ready; a byte is accepted on a cycle with TX_D_VLD=1 and TX_BUSY=0.
REQ-009 TX_P_DATA  output  BYTE_WIDTH  byte being offered downstream.
REQ-010 TX_D_VLD  output  1  TX_P_DATA valid.
REQ-011 SER_BUSY  output  1  high while a frame is in transmission or the holding buffer is occupied.
REQ-012 OVF  output  1  one-cycle pulse when a result is dropped.

Function
REQ-013 Frame SHALL be N = OUT_DATA_WIDTH/BYTE_WIDTH result bytes, least-significant byte first, followed by one status byte {zeros, Carry_OUT}; 5 bytes at default widths.
REQ-014 FSM states SHALL be IDLE and SEND; byte index counter runs 0..N.
REQ-015 IDLE: Arith_Flag=1 SHALL capture {Carry_OUT, Arith_OUT} into the shift register, enter SEND, and drive byte 0 with TX_D_VLD=1 on the next cycle (latency 1 cycle, all outputs registered).
REQ-016 SEND: TX_P_DATA and TX_D_VLD SHALL hold stable until accepted; on accept, the index increments and the next byte is presented the following cycle with no gap.
REQ-017 Acceptance of the status byte (index N) SHALL end the frame: load holding buffer if full, else load Arith_OUT if Arith_Flag=1 that cycle, else return to IDLE with TX_D_VLD=0.
REQ-018 Holding buffer, one entry: Arith_Flag=1 in SEND with buffer empty SHALL write the buffer.
REQ-019 Arith_Flag=1 in SEND with buffer full SHALL drop the new result and pulse OVF for one cycle, except on the cycle the status byte is accepted, when the buffer drains to the shift register and the new result is written to the buffer without drop.
REQ-020 Back-to-back frames SHALL have zero idle cycles between status byte acceptance and byte 0 of the next frame.
REQ-021 SER_BUSY SHALL equal (state==SEND) OR buffer-full, registered.
REQ-022 TX_BUSY held high indefinitely SHALL stall without loss; only OVF signals loss.

Reset
REQ-023 RST=1 at a clock edge SHALL force IDLE, index=0, buffer empty, TX_P_DATA=0, TX_D_VLD=0, SER_BUSY=0, OVF=0.
REQ-024 Reset mid-frame SHALL abandon the frame and buffer; no residual byte SHALL be offered after reset deasserts.
REQ-025 Arith_Flag during reset SHALL be ignored.

Structure
REQ-026 Shared package SHALL hold the FSM state encoding (IDLE, SEND) and default width constants shared with the arithmetic unit.
REQ-027 One sub-module SHALL be natural: result_hold_buffer (one-entry register with full flag, write, drain).
REQ-028 Target size 120-400 RTL lines; no latches, every combinational branch fully assigned.

Verification
REQ-029 Single result: Arith_OUT=0x12345678, Carry=1, TX_BUSY=0 -> bytes 0x78,0x56,0x34,0x12,0x01 on 5 consecutive cycles starting 1 cycle after strobe, then TX_D_VLD=0.
REQ-030 Backpressure: TX_BUSY=1 for 3 cycles during byte 2 -> TX_P_DATA=0x34 held stable, frame completes intact, OVF stays 0.
REQ-031 Buffered: second strobe 0xAABBCCDD, Carry=0 during frame 1 -> frame 2 bytes 0xDD,0xCC,0xBB,0xAA,0x00 immediately after frame 1 status byte, no gap.
REQ-032 Overflow: three strobes within frame 1 with TX_BUSY=1 -> third result dropped, OVF single-cycle pulse, frames 1 and 2 intact.
REQ-033 Simultaneous: strobe on status-byte accept cycle with buffer full -> buffered frame follows, new result buffered, OVF=0.
REQ-034 Reset mid-frame after byte 1 -> all outputs 0 next cycle, IDLE; a following strobe 0x00000001 sends 0x01,0x00,0x00,0x00,0x00.
